// File: rtl/cpu_run_scanner.sv
// cpu_run_scanner: holds the CPU in reset, lets it run until it halts
// (PC parked on a self-loop) or a cycle budget expires, then freezes it and
// streams every register-file entry out as (address, data) beats.
module cpu_run_scanner #(
  parameter int DATA_W     = 32,
  parameter int AW         = 5,
  parameter int PC_W       = 9,
  parameter int CNT_W      = 16,
  parameter int HALT_CNT   = 4,
  parameter int RST_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  max_cycles,
  input  logic [PC_W-1:0]   pc,
  input  logic [DATA_W-1:0] reg_data,
  output logic              cpu_rst,
  output logic              cpu_en,
  output logic [AW-1:0]     reg_addr,
  output logic              dump_valid,
  output logic [AW-1:0]     dump_addr,
  output logic [DATA_W-1:0] dump_data,
  output logic              busy,
  output logic              done,
  output logic              halted,
  output logic [CNT_W-1:0]  cycles
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RESET,
    S_RUN,
    S_SCAN,
    S_DONE
  } state_t;

  // Stable-PC counter only needs to reach HALT_CNT; reset counter only
  // needs to reach RST_CYCLES-1.
  localparam int SW = $clog2(HALT_CNT + 1);
  localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [AW-1:0]    ADDR_LAST = '1;
  localparam logic [SW-1:0]    HALT_LIM  = SW'(HALT_CNT);
  localparam logic [RW-1:0]    RST_LAST  = RW'(RST_CYCLES - 1);

  state_t          state;
  logic [RW-1:0]   rst_cnt;
  logic [SW-1:0]   stable;
  logic [PC_W-1:0] pc_prev;
  logic            pc_vld;
  logic            scan_end;

  logic [CNT_W-1:0] cycles_nxt;
  logic [CNT_W-1:0] cycle_limit;
  logic [SW-1:0]    stable_nxt;
  logic             halt_hit;
  logic             budget_hit;

  // Next-cycle run bookkeeping: saturating cycle count, stable-PC run length,
  // and the two run-ending conditions evaluated on those next values.
  always_comb begin
    cycles_nxt  = (cycles == CNT_MAX) ? cycles : cycles + 1'b1;
    cycle_limit = (max_cycles == '0) ? CNT_MAX : max_cycles;
    stable_nxt  = (pc_vld && (pc == pc_prev)) ? stable + 1'b1 : '0;
    halt_hit    = (stable_nxt == HALT_LIM);
    budget_hit  = (cycles_nxt == cycle_limit);
  end

  // Controller: sequencing, registered CPU controls and the dump beat stream.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cpu_rst    <= 1'b1;
      cpu_en     <= 1'b0;
      reg_addr   <= '0;
      dump_valid <= 1'b0;
      dump_addr  <= '0;
      dump_data  <= '0;
      halted     <= 1'b0;
      cycles     <= '0;
      rst_cnt    <= '0;
      stable     <= '0;
      pc_vld     <= 1'b0;
      scan_end   <= 1'b0;
    end else begin
      dump_valid <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state    <= S_RESET;
            cpu_rst  <= 1'b1;
            cpu_en   <= 1'b0;
            reg_addr <= '0;
            cycles   <= '0;
            halted   <= 1'b0;
            rst_cnt  <= '0;
            stable   <= '0;
            pc_vld   <= 1'b0;
            scan_end <= 1'b0;
          end
        end
        S_RESET: begin
          if (rst_cnt == RST_LAST) begin
            state   <= S_RUN;
            cpu_rst <= 1'b0;
            cpu_en  <= 1'b1;
          end else begin
            rst_cnt <= rst_cnt + 1'b1;
          end
        end
        S_RUN: begin
          cycles  <= cycles_nxt;
          pc_prev <= pc;
          pc_vld  <= 1'b1;
          stable  <= stable_nxt;
          // A halt seen on the budget's last cycle still reports as a halt.
          if (halt_hit || budget_hit) begin
            state  <= S_SCAN;
            cpu_en <= 1'b0;
            halted <= halt_hit;
          end
        end
        S_SCAN: begin
          // One extra cycle after the last address lets its beat drain
          // before DONE is entered.
          if (!scan_end) begin
            dump_valid <= 1'b1;
            dump_addr  <= reg_addr;
            dump_data  <= reg_data;
            if (reg_addr == ADDR_LAST) begin
              scan_end <= 1'b1;
              reg_addr <= '0;
            end else begin
              reg_addr <= reg_addr + 1'b1;
            end
          end else begin
            state <= S_DONE;
          end
        end
        default: begin
          state   <= S_IDLE;
          cpu_rst <= 1'b1;
          cpu_en  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = (state == S_RESET) || (state == S_RUN) || (state == S_SCAN);
  assign done = (state == S_DONE);

endmodule
